// File: rtl/args_plus_arb.sv
// args_plus_arb: round-robin scheduler sharing one pipelined N-input adder
// tree among R requesters. Requester IDs ride a tag pipeline matched to the
// tree latency, and results drain through a credit-protected output FIFO, so
// downstream back-pressure never drops a sum.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid[R]      per-requester request valid
//   req_data[R*W*N]   requester i at [i*W*N +: W*N], argument k at [k*W +: W]
//   req_ready[R]      combinational grant (one-hot or zero)
//   out_valid         FIFO head holds a result
//   out_ready         consumer accepts the head
//   out_sum[W+WP]     unsigned sum of the N arguments
//   out_id[IW]        originating requester index
//   busy              any tag in flight or FIFO non-empty
module args_plus_arb #(
    parameter int unsigned W = 10,
    parameter int unsigned N = 9,
    parameter int unsigned R = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [R-1:0]                req_valid,
    input  logic [R*W*N-1:0]            req_data,
    output logic [R-1:0]                req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [W+$clog2(N)-1:0]      out_sum,
    output logic [$clog2(R)-1:0]        out_id,
    output logic                        busy
);

    localparam int unsigned WP  = $clog2(N);
    localparam int unsigned LAT = WP + 1;
    localparam int unsigned D   = LAT + 2;
    localparam int unsigned IW  = $clog2(R);
    localparam int unsigned SW  = W + WP;
    localparam int unsigned NP  = 1 << WP;
    localparam int unsigned CW  = $clog2(D + 1);
    localparam int unsigned PW  = $clog2(D);

    // Arbiter / credit state
    logic [IW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;

    // Tag pipeline: valids are reset, ids are not
    logic [LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [LAT-1:0][IW-1:0]   tag_id_q, tag_id_d;

    // Adder tree stored as a heap: node i sums nodes 2i and 2i+1, leaves at NP..2NP-1
    logic [SW-1:0]          tree_q [2*NP-1:1];
    logic [SW-1:0]          tree_d [2*NP-1:1];

    // Output FIFO
    logic [SW-1:0]          fifo_sum_q [D];
    logic [IW-1:0]          fifo_id_q  [D];
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          occ_q, occ_d;
    logic                   out_valid_q, out_valid_d;

    // Combinational control
    logic                   sel_vld;
    logic [IW-1:0]          sel_idx;
    int unsigned            scan_idx;
    logic [W*N-1:0]         sel_data;
    logic [NP*W-1:0]        sel_pad;
    logic                   pop;
    logic                   acc;
    logic                   wr;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        scan_idx = 0;
        for (int unsigned off = 1; off <= R; off++) begin
            scan_idx = (32'(last_q) + off) % R;
            if (!sel_vld && req_valid[IW'(scan_idx)]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(scan_idx);
            end
        end
    end

    // Issue control; a same-cycle pop frees a credit when the pool is full
    always_comb begin
        pop       = out_valid_q & out_ready;
        acc       = !rst && sel_vld && ((cnt_q < CW'(D)) || pop);
        req_ready = acc ? (R'(1) << sel_idx) : '0;
        wr        = tag_vld_q[LAT-1];
        sel_data  = req_data[32'(sel_idx)*(W*N) +: W*N];
        sel_pad   = (NP*W)'(sel_data);
    end

    // Tree leaves take the selected vector (zero-padded to a power of two)
    for (genvar k = 0; k < NP; k++) begin : g_leaf
        assign tree_d[NP+k] = SW'(sel_pad[k*W +: W]);
    end

    for (genvar i = 1; i < NP; i++) begin : g_node
        assign tree_d[i] = tree_q[2*i] + tree_q[2*i+1];
    end

    // Next-state for arbiter, credit, tags and FIFO bookkeeping
    always_comb begin
        last_d      = last_q;
        cnt_d       = cnt_q;
        occ_d       = occ_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        tag_vld_d   = {tag_vld_q[LAT-2:0], acc};
        tag_id_d    = {tag_id_q[LAT-2:0], sel_idx};

        if (acc) begin
            last_d = sel_idx;
        end

        case ({acc, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        case ({wr, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        if (wr) begin
            wr_ptr_d = (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        out_valid_d = (occ_d != '0);
        busy_d      = (cnt_d != '0);
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= IW'(R - 1);
            cnt_q       <= '0;
            occ_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            tag_vld_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            tag_vld_q   <= tag_vld_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Datapath: tree, tag ids and FIFO storage carry no reset
    always_ff @(posedge clk) begin
        tree_q   <= tree_d;
        tag_id_q <= tag_id_d;
        if (wr) begin
            fifo_sum_q[wr_ptr_q] <= tree_q[1];
            fifo_id_q[wr_ptr_q]  <= tag_id_q[LAT-1];
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = fifo_sum_q[rd_ptr_q];
    assign out_id    = fifo_id_q[rd_ptr_q];

endmodule

// File: tb/tb_args_plus_arb.sv
// Bench for args_plus_arb: a cycle-level reference model predicts grants,
// output timing and busy; accepted vectors are queued as expected results and
// a separate monitor compares each DUT output against that queue.
module tb_args_plus_arb;

    localparam int unsigned W   = 10;
    localparam int unsigned N   = 9;
    localparam int unsigned R   = 4;
    localparam int unsigned WP  = 4;
    localparam int unsigned LAT = WP + 1;
    localparam int unsigned D   = LAT + 2;
    localparam int unsigned IW  = 2;
    localparam int unsigned SW  = W + WP;

    logic               clk = 1'b0;
    logic               rst;
    logic [R-1:0]       req_valid;
    logic [R*W*N-1:0]   req_data;
    logic [R-1:0]       req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [SW-1:0]      out_sum;
    logic [IW-1:0]      out_id;
    logic               busy;

    args_plus_arb #(.W(W), .N(N), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        int unsigned sum;
        int unsigned avail;
    } ent_t;

    ent_t        mq[$];     // model: accepted, not yet popped, with visibility cycle
    ent_t        sb[$];     // scoreboard: expected outputs in order
    int unsigned cyc = 0;
    int          last_m;
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          dmode = 0;
    int unsigned max_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (32'(dut.cnt_q) > max_cnt) max_cnt = 32'(dut.cnt_q);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus plus model update
    task automatic step(input logic [R-1:0] v, input logic ordy);
        logic [R*W*N-1:0] d_in;
        ent_t             e;
        bit               found;
        bit               pop_e;
        bit               allowed;
        bit               ov_e;
        int               sel;
        int               idx;
        logic [R-1:0]     exp_rdy;

        @(negedge clk);
        for (int i = 0; i < R; i++) begin
            for (int k = 0; k < N; k++) begin
                case (dmode)
                    1:       d_in[(i*N+k)*W +: W] = W'(1023);
                    2:       d_in[(i*N+k)*W +: W] = W'(i + 1);
                    default: d_in[(i*N+k)*W +: W] = W'($urandom_range(0, 1023));
                endcase
            end
        end
        req_data  = d_in;
        req_valid = v;
        out_ready = ordy;
        #1;

        ov_e  = (mq.size() > 0) && (mq[0].avail <= cyc);
        pop_e = ov_e && ordy;
        chk("out_valid", 64'(out_valid), 64'(ov_e));
        chk("busy", 64'(busy), 64'(mq.size() != 0));

        found = 1'b0;
        sel   = 0;
        for (int off = 1; off <= R; off++) begin
            idx = (last_m + off) % R;
            if (!found && v[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        allowed = (mq.size() < D) || pop_e;
        exp_rdy = (found && allowed) ? R'(1 << sel) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));

        if (found && allowed) begin
            e.id  = sel;
            e.sum = 0;
            for (int k = 0; k < N; k++) e.sum += 32'(d_in[(sel*N+k)*W +: W]);
            e.avail = cyc + 1 + LAT;
            mq.push_back(e);
            sb.push_back(e);
            last_m = sel;
            acc_cnt++;
        end
        if (pop_e) void'(mq.pop_front());
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() > 0 && n < 60) begin
            step('0, 1'b1);
            n++;
        end
        step('0, 1'b1);
        step('0, 1'b1);
        chk("drain_model_empty", 64'(mq.size()), 0);
        chk("drain_sb_empty", 64'(sb.size()), 0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        mq.delete();
        sb.delete();
        last_m = R - 1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pop expected result whenever the DUT hands one over
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got id %0d sum %0d expected none", out_id, out_sum);
                end else begin
                    e = sb.pop_front();
                    chk("out_id", 64'(out_id), 64'(e.id));
                    chk("out_sum", 64'(out_sum), 64'(e.sum));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        last_m    = R - 1;
        do_reset(3);

        // Single request from requester 2, all args max
        dmode = 1;
        step(4'b0100, 1'b1);
        chk("single_grant", 64'(req_ready), 64'(4'b0100));
        dmode = 0;
        repeat (10) step('0, 1'b1);
        drain();

        // Fairness with every requester valid
        dmode = 2;
        repeat (12) step(4'b1111, 1'b1);
        dmode = 0;
        drain();

        // Back-pressure: credits run out after D acceptances
        acc_cnt = 0;
        repeat (12) step(4'b1111, 1'b0);
        chk("bp_accepts", 64'(acc_cnt), 64'(D));
        step(4'b1111, 1'b1);
        chk("bp_pop_and_accept", 64'(acc_cnt), 64'(D + 1));
        drain();

        // Sparse requests across the pointer wrap
        repeat (6) step(4'b1000, 1'($urandom_range(0, 1)));
        repeat (6) step(4'b0001, 1'($urandom_range(0, 1)));
        drain();

        // Reset with operations in flight
        repeat (3) step(4'b1111, 1'b1);
        repeat (2) step('0, 1'b1);
        do_reset(2);
        step(4'b1111, 1'b1);
        chk("post_reset_grant", 64'(req_ready), 64'(4'b0001));
        repeat (3) step(4'b0110, 1'b1);
        drain();

        // Random soak
        for (int c = 0; c < 10000; c++) begin
            step(R'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain();
        chk("cnt_within_limit", 64'(max_cnt <= D), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
